hazard_control: RTL and testbench

Pipeline sequencing controller for the five-stage RISC V core. Generates the PC enable, the fetch/decode register enable, and the nop (clear) signals for the decoding stage and the execute-input register. Handles three hazard classes:
- load-use data hazards,
- taken-branch control hazards,
- data-memory wait states.
Also keeps two saturating performance counters.

---
 rtl/hazard_control.sv | 132 +++++++++++++
 tb/tb_hazard_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// Pipeline sequencing controller: load-use stalls, taken-branch squash and
// data-memory wait states, plus saturating stall/flush performance counters.
module hazard_control #(
   parameter int unsigned LU_DEPTH    = 1,
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rr1_d,
   input  logic [4:0]       rr2_d,
   input  logic [4:0]       rw_x,
   input  logic             memread_x,
   input  logic             branch_taken_x,
   input  logic             mem_req_m,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             nop_d,
   output logic             nop_x,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      FLUSH      = 2'b10,
      ILLEGAL    = 2'b11
   } state_e;

   localparam logic [2:0] LU_RELOAD = 3'(LU_DEPTH - 1);
   localparam logic [2:0] FL_RELOAD = 3'(FLUSH_DEPTH - 1);

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic             freeze, lu_hazard, flush_inc;

   assign freeze    = mem_req_m & ~mem_ready;
   assign lu_hazard = memread_x & (rw_x != 5'd0) & ((rw_x == rr1_d) | (rw_x == rr2_d));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      flush_inc = 1'b0;
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      nop_d     = 1'b0;
      nop_x     = 1'b0;

      if (freeze) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               // Branch beats load-use: the decode instruction is wrong-path anyway.
               if (branch_taken_x) begin
                  nop_d     = 1'b1;
                  nop_x     = 1'b1;
                  flush_inc = 1'b1;
                  if (FLUSH_DEPTH > 1) begin
                     state_d = FLUSH;
                     cnt_d   = FL_RELOAD;
                  end
               end else if (lu_hazard) begin
                  pc_en    = 1'b0;
                  if_id_en = 1'b0;
                  nop_x    = 1'b1;
                  if (LU_DEPTH > 1) begin
                     state_d = LOAD_STALL;
                     cnt_d   = LU_RELOAD;
                  end
               end
            end
            FLUSH: begin
               nop_d = 1'b1;
               nop_x = 1'b1;
               cnt_d = cnt_q - 3'd1;
               if (cnt_q <= 3'd1) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end
            end
            LOAD_STALL: begin
               pc_en    = 1'b0;
               if_id_en = 1'b0;
               nop_x    = 1'b1;
               cnt_d    = cnt_q - 3'd1;
               if (cnt_q <= 3'd1) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end

      if (rst) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         nop_d    = 1'b1;
         nop_x    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (!pc_en && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_inc && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: a vector table against the default
// configuration and hand sequences against a deep-stall, narrow-counter instance.
module tb_hazard_control;

   typedef struct {
      logic [4:0]  rr1, rr2, rw;
      logic        mr, br, req, rdy;
      logic        pc, ifid, nd, nx;
      logic [1:0]  st;
      logic [15:0] sc, fc;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: LU_DEPTH=1, FLUSH_DEPTH=2, CNT_W=16
   logic       rst_a;
   logic [4:0] a_rr1, a_rr2, a_rw;
   logic       a_mr, a_br, a_req, a_rdy;
   logic       a_pc, a_ifid, a_nd, a_nx;
   logic [1:0] a_st;
   logic [15:0] a_sc, a_fc;

   hazard_control #(.LU_DEPTH(1), .FLUSH_DEPTH(2), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst_a), .rr1_d(a_rr1), .rr2_d(a_rr2), .rw_x(a_rw),
      .memread_x(a_mr), .branch_taken_x(a_br), .mem_req_m(a_req), .mem_ready(a_rdy),
      .pc_en(a_pc), .if_id_en(a_ifid), .nop_d(a_nd), .nop_x(a_nx), .state(a_st),
      .stall_cnt(a_sc), .flush_cnt(a_fc)
   );

   // Instance B: LU_DEPTH=4, FLUSH_DEPTH=3, CNT_W=4
   logic       rst_b;
   logic [4:0] b_rr1, b_rr2, b_rw;
   logic       b_mr, b_br, b_req, b_rdy;
   logic       b_pc, b_ifid, b_nd, b_nx;
   logic [1:0] b_st;
   logic [3:0] b_sc, b_fc;

   hazard_control #(.LU_DEPTH(4), .FLUSH_DEPTH(3), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst_b), .rr1_d(b_rr1), .rr2_d(b_rr2), .rw_x(b_rw),
      .memread_x(b_mr), .branch_taken_x(b_br), .mem_req_m(b_req), .mem_ready(b_rdy),
      .pc_en(b_pc), .if_id_en(b_ifid), .nop_d(b_nd), .nop_x(b_nx), .state(b_st),
      .stall_cnt(b_sc), .flush_cnt(b_fc)
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] rr1, rr2, rw, input logic mr, br, req, rdy,
                               input logic pc, ifid, nd, nx, input logic [1:0] st,
                               input logic [15:0] sc, fc);
      vec_t v;
      v.rr1 = rr1; v.rr2 = rr2; v.rw = rw; v.mr = mr; v.br = br; v.req = req; v.rdy = rdy;
      v.pc = pc; v.ifid = ifid; v.nd = nd; v.nx = nx; v.st = st; v.sc = sc; v.fc = fc;
      return v;
   endfunction

   task automatic b_drive(input logic [4:0] rr1, rr2, rw, input logic mr, br, req, rdy);
      b_rr1 = rr1; b_rr2 = rr2; b_rw = rw; b_mr = mr; b_br = br; b_req = req; b_rdy = rdy;
   endtask

   task automatic b_chk(input int idx, input logic pc, ifid, nd, nx, input logic [1:0] st,
                        input logic [3:0] sc, fc);
      chk("b_pc_en", idx, 32'(b_pc), 32'(pc));
      chk("b_if_id_en", idx, 32'(b_ifid), 32'(ifid));
      chk("b_nop_d", idx, 32'(b_nd), 32'(nd));
      chk("b_nop_x", idx, 32'(b_nx), 32'(nx));
      chk("b_state", idx, 32'(b_st), 32'(st));
      chk("b_stall_cnt", idx, 32'(b_sc), 32'(sc));
      chk("b_flush_cnt", idx, 32'(b_fc), 32'(fc));
   endtask

   vec_t tbl[18];

   initial begin
      //          rr1 rr2 rw  mr br rq rd  pc if nd nx st  sc fc
      tbl[0]  = mk(1, 2, 3,  0, 0, 0, 0,  1, 1, 0, 0, 0,  0, 0); // normal
      tbl[1]  = mk(5, 2, 5,  1, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0); // load-use on rr1
      tbl[2]  = mk(5, 2, 5,  0, 0, 0, 0,  1, 1, 0, 0, 0,  1, 0); // single bubble done
      tbl[3]  = mk(0, 0, 0,  1, 0, 0, 0,  1, 1, 0, 0, 0,  1, 0); // rw_x=0 never hazards
      tbl[4]  = mk(1, 7, 7,  1, 0, 0, 0,  0, 0, 0, 1, 0,  1, 0); // load-use on rr2
      tbl[5]  = mk(6, 8, 7,  1, 0, 0, 0,  1, 1, 0, 0, 0,  2, 0); // load, no match
      tbl[6]  = mk(5, 2, 5,  1, 1, 0, 0,  1, 1, 1, 1, 0,  2, 0); // branch beats load-use
      tbl[7]  = mk(5, 2, 5,  1, 1, 0, 0,  1, 1, 1, 1, 2,  2, 1); // flush ignores hazards
      tbl[8]  = mk(1, 2, 3,  0, 0, 0, 0,  1, 1, 0, 0, 0,  2, 1); // back to run
      tbl[9]  = mk(1, 2, 3,  0, 1, 0, 0,  1, 1, 1, 1, 0,  2, 1); // second branch
      tbl[10] = mk(1, 2, 3,  0, 0, 1, 0,  0, 0, 0, 0, 2,  2, 2); // freeze mid-flush
      tbl[11] = mk(1, 2, 3,  0, 0, 1, 0,  0, 0, 0, 0, 2,  3, 2);
      tbl[12] = mk(1, 2, 3,  0, 0, 1, 0,  0, 0, 0, 0, 2,  4, 2);
      tbl[13] = mk(1, 2, 3,  0, 0, 1, 1,  1, 1, 1, 1, 2,  5, 2); // remaining flush cycle
      tbl[14] = mk(1, 2, 3,  0, 0, 0, 0,  1, 1, 0, 0, 0,  5, 2);
      tbl[15] = mk(1, 2, 3,  0, 1, 1, 0,  0, 0, 0, 0, 0,  5, 2); // freeze masks branch
      tbl[16] = mk(5, 2, 5,  1, 0, 1, 0,  0, 0, 0, 0, 0,  6, 2); // freeze masks load-use
      tbl[17] = mk(1, 2, 3,  0, 0, 0, 0,  1, 1, 0, 0, 0,  7, 2);

      rst_a = 1'b1; rst_b = 1'b1;
      a_rr1 = 5'd1; a_rr2 = 5'd2; a_rw = 5'd3; a_mr = 1'b0; a_br = 1'b0; a_req = 1'b0; a_rdy = 1'b0;
      b_drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset state of both instances
      @(negedge clk); @(negedge clk); #1;
      chk("a_rst_pc_en", 0, 32'(a_pc), 32'd0);
      chk("a_rst_if_id_en", 0, 32'(a_ifid), 32'd0);
      chk("a_rst_nop_d", 0, 32'(a_nd), 32'd1);
      chk("a_rst_nop_x", 0, 32'(a_nx), 32'd1);
      chk("a_rst_state", 0, 32'(a_st), 32'd0);
      chk("a_rst_stall_cnt", 0, 32'(a_sc), 32'd0);
      chk("a_rst_flush_cnt", 0, 32'(a_fc), 32'd0);
      b_chk(0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 4'd0);

      @(negedge clk); rst_a = 1'b0;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         a_rr1 = tbl[i].rr1; a_rr2 = tbl[i].rr2; a_rw = tbl[i].rw; a_mr = tbl[i].mr;
         a_br = tbl[i].br; a_req = tbl[i].req; a_rdy = tbl[i].rdy;
         #1;
         chk("a_pc_en", i, 32'(a_pc), 32'(tbl[i].pc));
         chk("a_if_id_en", i, 32'(a_ifid), 32'(tbl[i].ifid));
         chk("a_nop_d", i, 32'(a_nd), 32'(tbl[i].nd));
         chk("a_nop_x", i, 32'(a_nx), 32'(tbl[i].nx));
         chk("a_state", i, 32'(a_st), 32'(tbl[i].st));
         chk("a_stall_cnt", i, 32'(a_sc), 32'(tbl[i].sc));
         chk("a_flush_cnt", i, 32'(a_fc), 32'(tbl[i].fc));
      end

      // B: async reset in the middle of a load stall
      @(negedge clk); rst_b = 1'b0; #1;
      b_chk(1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
      @(negedge clk); b_drive(5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      b_chk(2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'd0);
      @(negedge clk); b_drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      b_chk(3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd1, 4'd0);
      #2 rst_b = 1'b1; #1;
      b_chk(4, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0, 4'd0);
      @(negedge clk); rst_b = 1'b0; #1;
      b_chk(5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);

      // B: three-cycle squash
      @(negedge clk); b_drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0); #1;
      b_chk(6, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'd0, 4'd0);
      @(negedge clk); b_drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      b_chk(7, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'd0, 4'd1);
      @(negedge clk); #1;
      b_chk(8, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'd0, 4'd1);
      @(negedge clk); #1;
      b_chk(9, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd1);

      // B: four-bubble load-use, branch ignored while stalled
      @(negedge clk); b_drive(5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      b_chk(10, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'd1);
      @(negedge clk); b_drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      b_chk(11, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd1, 4'd1);
      @(negedge clk); b_drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0); #1;
      b_chk(12, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd2, 4'd1);
      @(negedge clk); b_drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      b_chk(13, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd3, 4'd1);
      @(negedge clk); #1;
      b_chk(14, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd4, 4'd1);

      // B: long freeze saturates the 4-bit stall counter
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); b_drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0); #1;
         b_chk(100 + k, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, (4 + k > 15) ? 4'd15 : 4'(4 + k), 4'd1);
      end
      @(negedge clk); b_drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      b_chk(200, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd15, 4'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
